// File: rtl/iddmm_seq_ctrl.sv
// Sequencer for the iddmm_cal Montgomery-multiply datapath: walks rows/columns,
// leads operand-RAM reads by one cycle, drains between rows and awaits cal_done.
module iddmm_seq_ctrl #(
  parameter int unsigned N       = 16,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned GAP     = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              result_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_x_addr,
  output logic [ADDR_W:0]   rd_j_addr,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic              loop_en,
  input  logic              cal_done,
  input  logic              cal_sign
);

  localparam int unsigned JW = ADDR_W + 1;
  localparam int unsigned CW = 8;
  localparam logic [JW-1:0]     J_LAST   = JW'(N);
  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_ROW, ST_GAP, ST_WAIT_DONE, ST_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]     to_cnt_q, to_cnt_d;
  logic              busy_d, done_d, err_d, result_sel_d, rd_en_d, loop_en_d;
  logic [ADDR_W-1:0] rd_x_addr_d, i_cnt_d;
  logic [JW-1:0]     rd_j_addr_d, j_cnt_d;

  // State, counters and all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result_sel <= 1'b0;
      rd_en      <= 1'b0;
      rd_x_addr  <= '0;
      rd_j_addr  <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      loop_en    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      result_sel <= result_sel_d;
      rd_en      <= rd_en_d;
      rd_x_addr  <= rd_x_addr_d;
      rd_j_addr  <= rd_j_addr_d;
      i_cnt      <= i_cnt_d;
      j_cnt      <= j_cnt_d;
      loop_en    <= loop_en_d;
    end
  end

  // Next-state and next-output logic; values describe the following cycle
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = 1'b0;
    result_sel_d = result_sel;
    rd_en_d      = 1'b0;
    rd_x_addr_d  = rd_x_addr;
    rd_j_addr_d  = rd_j_addr;
    i_cnt_d      = i_cnt;
    j_cnt_d      = j_cnt;
    loop_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = ST_PRE;
          busy_d      = 1'b1;
          rd_en_d     = 1'b1;
          rd_x_addr_d = '0;
          rd_j_addr_d = '0;
          i_cnt_d     = '0;
          j_cnt_d     = '0;
        end
      end
      ST_PRE: begin
        state_d     = ST_ROW;
        loop_en_d   = 1'b1;
        j_cnt_d     = '0;
        rd_en_d     = 1'b1;
        rd_j_addr_d = JW'(1);
      end
      ST_ROW: begin
        if (j_cnt != J_LAST) begin
          loop_en_d = 1'b1;
          j_cnt_d   = j_cnt + JW'(1);
          // Read port runs one column ahead and stops after column N
          if (j_cnt + JW'(1) != J_LAST) begin
            rd_en_d     = 1'b1;
            rd_j_addr_d = j_cnt + JW'(2);
          end
        end else begin
          j_cnt_d     = '0;
          rd_j_addr_d = '0;
          if (i_cnt != I_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            if (GAP_LAST == '0) begin
              rd_en_d     = 1'b1;
              rd_x_addr_d = i_cnt + ADDR_W'(1);
            end
          end else begin
            state_d  = ST_WAIT_DONE;
            to_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d     = ST_ROW;
          i_cnt_d     = i_cnt + ADDR_W'(1);
          j_cnt_d     = '0;
          loop_en_d   = 1'b1;
          rd_en_d     = 1'b1;
          rd_j_addr_d = JW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + CW'(1);
          // Prefetch column 0 of the next row in the final drain cycle
          if (gap_cnt_q + CW'(1) == GAP_LAST) begin
            rd_en_d     = 1'b1;
            rd_x_addr_d = i_cnt + ADDR_W'(1);
            rd_j_addr_d = '0;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (cal_done) begin
          state_d      = ST_FIN;
          result_sel_d = cal_sign;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          i_cnt_d      = '0;
          rd_x_addr_d  = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_IDLE;
          err_d       = 1'b1;
          busy_d      = 1'b0;
          i_cnt_d     = '0;
          rd_x_addr_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition outside IDLE; result_sel is kept
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      gap_cnt_d    = '0;
      to_cnt_d     = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      result_sel_d = result_sel;
      rd_en_d      = 1'b0;
      rd_x_addr_d  = '0;
      rd_j_addr_d  = '0;
      i_cnt_d      = '0;
      j_cnt_d      = '0;
      loop_en_d    = 1'b0;
    end
  end

endmodule

// File: doc/iddmm_seq_ctrl.md
Name: iddmm_seq_ctrl

Overview:
- Sequencer for the iddmm_cal Montgomery-multiply datapath.
- On a start request it drives the outer word index i_cnt, inner word index j_cnt and loop_en to the datapath.
- It issues operand-RAM read addresses one cycle ahead of those indices, inserts pipeline-drain gaps between rows, and waits for cal_done.
- It then returns a done pulse with the latched result-select sign, plus timeout and abort handling.

Parameters:
- N, 16, number of K-bit words per operand.
- ADDR_W, $clog2(N), word index width.
- GAP, 12, idle cycles between consecutive rows; covers datapath q-feedback latency. Legal range is 1..255.
- TIMEOUT, 64, maximum cycles in WAIT_DONE before an error is flagged. Legal range is 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- abort  input  1  synchronous abort, any state.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse when the result is ready.
- err  output  1  one-cycle pulse on timeout.
- result_sel  output  1  latched cal_sign; 1 selects the subtracted result FIFO.
- rd_en  output  1  operand RAM read enable.
- rd_x_addr  output  ADDR_W  x word address (row index).
- rd_j_addr  output  ADDR_W+1  y/p/a word address (column index).
- i_cnt  output  ADDR_W  to datapath.
- j_cnt  output  ADDR_W+1  to datapath.
- loop_en  output  1  to datapath; high during valid row cycles.
- cal_done  input  1  datapath completion pulse.
- cal_sign  input  1  datapath result sign, valid with cal_done.

Behaviour:
- All outputs are registered.
- Reset values are all zero: busy, done, err, result_sel, rd_en, rd_x_addr, rd_j_addr, i_cnt, j_cnt, loop_en. FSM resets to IDLE. Reset mid-operation returns to IDLE immediately with no done.
- States: IDLE, PRE, ROW, GAP, WAIT_DONE, FIN.
- IDLE:
  - start=1 moves to PRE.
  - rd_en=1, rd_x_addr=0, rd_j_addr=0 on the next cycle.
  - busy=1 on the next cycle.
- PRE (1 cycle): moves to ROW. Address counter advances.
- ROW (N+1 cycles per row):
  - loop_en=1; j_cnt steps 0,1,...,N; i_cnt holds the current row.
  - rd_en/rd_j_addr lead j_cnt by exactly 1 cycle: at the cycle j_cnt=k, the previous cycle presented rd_j_addr=k.
  - rd_en deasserts the cycle j_cnt=N is driven.
  - At the end of the row: if i_cnt<N-1, go to GAP; else go to WAIT_DONE.
- GAP (GAP cycles): loop_en=0, j_cnt=0, i_cnt holds.
  - In the last GAP cycle: rd_en=1, rd_x_addr=i+1, rd_j_addr=0.
  - Then go to ROW with i_cnt=i+1, j_cnt=0.
- WAIT_DONE:
  - loop_en=0, i_cnt=N-1, j_cnt=0; timeout counter runs.
  - cal_done=1: latch result_sel<=cal_sign, go to FIN.
  - Counter reaching TIMEOUT with no cal_done: pulse err 1 cycle, go to IDLE, result_sel unchanged.
- FIN: done=1 for 1 cycle, busy drops the same cycle, next state IDLE.
- cal_done outside WAIT_DONE is ignored.
- start outside IDLE is ignored. start in the FIN cycle is ignored; it must be re-asserted in IDLE.
- abort, in any non-IDLE state, has priority over all other transitions:
  - next cycle: IDLE, loop_en=0, rd_en=0, counters=0, busy=0.
  - no done, no err.
  - result_sel holds.
- Cycle count: from the first ROW cycle to the last ROW cycle inclusive = N*(N+1)+(N-1)*GAP.
- Width rules: j_cnt never exceeds N; i_cnt never exceeds N-1; no wrap-around is permitted.

Test Plan:
- Basic run, N=4, GAP=12: pulse start; cal_done with cal_sign=1 arrives 20 cycles into WAIT_DONE.
  - Required: loop_en high 5 cycles per row, 4 rows; 56 cycles from first to last ROW cycle.
  - Required: j_cnt sequence 0..4 per row; i_cnt 0..3; done pulses once; result_sel=1; busy low after done.
- Address lead: check every cycle with loop_en=1 that rd_j_addr in the previous cycle equals j_cnt, and rd_x_addr equals i_cnt.
- Timeout, TIMEOUT=64: no cal_done → err pulse exactly 64 cycles after entering WAIT_DONE; done stays 0; busy drops; result_sel keeps its prior value.
- Abort: assert abort during row i=2, j=3 → next cycle all counters 0, loop_en=0, busy=0; no done; a new start then yields a full normal run.
- Ignored events:
  - start pulses while busy → no restart; the cycle count is unchanged.
  - Spurious cal_done during ROW → no state change; the later real cal_done with cal_sign=0 gives result_sel=0.
- Reset mid-run: drop rst_n during GAP → all outputs 0 asynchronously; after release the FSM is in IDLE and waits for start.
